aes_encryption: RTL and testbench
=================================

Name: aes_encryption

Overview:
- Multicycle AES-256 encryption core (FIPS-197) for a single 128-bit block.
- After reset deasserts it samples `plaintext` and `initial_key` once, then does one round per clock.
- Key expansion runs alongside the rounds, one round key per cycle.
- It exposes the ciphertext and the full expanded key schedule (15 round keys) as flat outputs for downstream logic and debug.

Parameters:
- None. Key size is fixed at 256 bits, block size at 128 bits, round count at 14.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- plaintext  input  128  block to encrypt; bit 127 is the first byte's MSB (FIPS byte order, byte 0 in [127:120]).
- initial_key  input  256  cipher key; byte 0 in [255:248].
- ciphertext  output  128  encrypted block, same byte order; registered.
- key_chain  output  1920  expanded key; round key i (i = 0..14) occupies [1919-128*i -: 128]; registered.

Behaviour:
- One clock, clk_i; reset_i is synchronous and active-high.
- FSM states: LOAD, ROUND, DONE.
- While reset_i is high at a rising edge:
  - FSM goes to LOAD, round counter goes to 0.
  - State register, ciphertext and key_chain clear to all zeros.
  - Reset has priority in every state, so a reset mid-operation aborts and restarts.
- LOAD (first edge with reset_i low):
  - Latch `initial_key` into key_chain slots 0 and 1: rk0 = key[255:128], rk1 = key[127:0].
  - state = plaintext XOR key[255:128].
  - Round counter goes to 1; go to ROUND.
- ROUND (round r = 1..14, one edge each):
  - If r >= 2, compute rk[r] from rk[r-2] and rk[r-1] and write it into key_chain slot r the same edge.
  - Word rule: w[k] = w[k-8] XOR t.
    - For the first word of an even-index key: t = SubWord(RotWord(w[k-1])) XOR Rcon[r/2], with Rcon = 01,02,04,08,10,20,40 in the MSB byte.
    - For the first word of an odd-index key: t = SubWord(w[k-1]).
    - For the other words: t = w[k-1].
  - Rounds 1..13: state = MixColumns(ShiftRows(SubBytes(state))) XOR rk[r].
  - Round 14: state = ShiftRows(SubBytes(state)) XOR rk14, with no MixColumns; the result is also written to ciphertext; go to DONE.
- DONE:
  - Hold ciphertext and key_chain stable.
  - Ignore input changes until the next reset.
- Latency:
  - ciphertext is valid after the 15th rising edge following the first reset-low edge, i.e. LOAD plus 14 rounds.
  - key_chain is complete at the same edge.
  - Before that, ciphertext reads 0 and key_chain is partially filled; unfilled slots read 0.
- Input sampling: inputs are sampled only in LOAD; changes during ROUND or DONE have no effect.
- S-box: the standard AES S-box (combinational, 16 instances for SubBytes plus 4 for SubWord).
- MixColumns: GF(2^8) with xtime reduction polynomial 0x11B.
- No handshake: the bench waits a fixed number of cycles for the result.

Test Plan:
- FIPS-197 C.3 vector: reset 1 cycle, then plaintext=00112233445566778899aabbccddeeff, key=000102...1e1f, wait 50 cycles.
  - Expect ciphertext = 8ea2b7ca516745bfeafc49904b496089.
  - Expect key_chain[1919:1664] = key.
  - Expect key_chain[127:0] (rk14) = 24fc79ccbf0979e9371ac23c6d68de36.
- All-zero key and plaintext, wait 50 cycles -> ciphertext = dc95c078a2408989ad48a21492842087.
- Latency check with the C.3 vector: ciphertext is 0 after 14 reset-low edges and correct after exactly 15; key_chain is unchanged from then on.
- Reset held high -> ciphertext = 0 and key_chain = 0 every cycle.
- Assert reset at round 7 of the C.3 run, then apply the zero vector -> outputs clear, and 15 edges later ciphertext = dc95c078a2408989ad48a21492842087.
- Change plaintext and initial_key after the LOAD edge of the C.3 run -> ciphertext still = 8ea2b7ca516745bfeafc49904b496089.

Source files
------------

// File: rtl/aes_encryption.sv
// Multicycle AES-256 encryption core: one load cycle, then one round per clock
// with on-the-fly key expansion. Exposes the ciphertext and the full key schedule.
module aes_encryption (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [127:0]  plaintext,
    input  logic [255:0]  initial_key,
    output logic [127:0]  ciphertext,
    output logic [1919:0] key_chain
);

    localparam int unsigned BLK_W  = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned NUM_RK = 15;
    localparam int unsigned RND_W  = 4;
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(14);

    // Element 255 holds S(0x00), so the table is indexed with the inverted byte.
    localparam logic [255:0][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {LOAD, ROUND, DONE} state_e;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[~b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [WORD_W-1:0] mix_col(input logic [WORD_W-1:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    state_e             state_q, state_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [BLK_W-1:0]   ct_q, ct_d;
    logic [BLK_W-1:0]   rk_q [NUM_RK];
    logic [BLK_W-1:0]   rk_d [NUM_RK];

    logic [BLK_W-1:0]   prev2_c, new_rk_c, rk_cur_c;
    logic [WORD_W-1:0]  prev1_c, sw_in_c, sw_out_c, t_c;
    logic [WORD_W-1:0]  nw0_c, nw1_c, nw2_c, nw3_c;
    logic [7:0]         rcon_c;
    logic [BLK_W-1:0]   sb_c, sr_c, mc_c;

    // Next round key from the two previous ones.
    always_comb begin
        prev2_c = '0;
        prev1_c = '0;
        for (int i = 0; i < NUM_RK; i++) begin
            if (RND_W'(i) == rnd_q - RND_W'(2)) prev2_c = rk_q[i];
            if (RND_W'(i) == rnd_q - RND_W'(1)) prev1_c = rk_q[i][WORD_W-1:0];
        end
        sw_in_c  = rnd_q[0] ? prev1_c : {prev1_c[23:0], prev1_c[31:24]};
        sw_out_c = '0;
        for (int b = 0; b < 4; b++) sw_out_c[8*b +: 8] = sbox(sw_in_c[8*b +: 8]);
        rcon_c   = 8'h01 << (rnd_q[3:1] - 3'd1);
        t_c      = rnd_q[0] ? sw_out_c : (sw_out_c ^ {rcon_c, 24'h000000});
        nw0_c    = prev2_c[127:96] ^ t_c;
        nw1_c    = prev2_c[95:64]  ^ nw0_c;
        nw2_c    = prev2_c[63:32]  ^ nw1_c;
        nw3_c    = prev2_c[31:0]   ^ nw2_c;
        new_rk_c = {nw0_c, nw1_c, nw2_c, nw3_c};
        rk_cur_c = (rnd_q < RND_W'(2)) ? rk_q[1] : new_rk_c;
    end

    // SubBytes, ShiftRows, MixColumns on the current state (column-major bytes).
    always_comb begin
        sb_c = '0;
        sr_c = '0;
        mc_c = '0;
        for (int b = 0; b < 16; b++) sb_c[127-8*b -: 8] = sbox(blk_q[127-8*b -: 8]);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_c[127-8*(r+4*c) -: 8] = sb_c[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) mc_c[127-32*c -: 32] = mix_col(sr_c[127-32*c -: 32]);
    end

    // Control: load, 14 rounds, then hold.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        blk_d   = blk_q;
        ct_d    = ct_q;
        rk_d    = rk_q;
        case (state_q)
            LOAD: begin
                rk_d[0] = initial_key[255:128];
                rk_d[1] = initial_key[127:0];
                blk_d   = plaintext ^ initial_key[255:128];
                rnd_d   = RND_W'(1);
                state_d = ROUND;
            end
            ROUND: begin
                for (int i = 2; i < NUM_RK; i++) begin
                    if (rnd_q == RND_W'(i)) rk_d[i] = new_rk_c;
                end
                if (rnd_q == LAST_RND) begin
                    blk_d   = sr_c ^ rk_cur_c;
                    ct_d    = sr_c ^ rk_cur_c;
                    state_d = DONE;
                end else begin
                    blk_d = mc_c ^ rk_cur_c;
                    rnd_d = rnd_q + RND_W'(1);
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= LOAD;
            rnd_q   <= '0;
            blk_q   <= '0;
            ct_q    <= '0;
            for (int i = 0; i < NUM_RK; i++) rk_q[i] <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            blk_q   <= blk_d;
            ct_q    <= ct_d;
            for (int i = 0; i < NUM_RK; i++) rk_q[i] <= rk_d[i];
        end
    end

    assign ciphertext = ct_q;

    for (genvar g = 0; g < NUM_RK; g++) begin : g_key_chain
        assign key_chain[1919-128*g -: 128] = rk_q[g];
    end

endmodule

// File: tb/tb_aes_encryption.sv
// Bench for aes_encryption: a FIPS-197 reference model (S-box derived from GF(2^8)
// inverses) predicts ciphertext and key_chain on every cycle, plus directed vectors.
module tb_aes_encryption;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [127:0]  plaintext;
    logic [255:0]  initial_key;
    logic [127:0]  ciphertext;
    logic [1919:0] key_chain;

    localparam logic [127:0] PT_C3  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] RK14_C3 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    localparam logic [127:0] CT_ZERO = 128'hdc95c078a2408989ad48a21492842087;

    aes_encryption dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .plaintext  (plaintext),
        .initial_key(initial_key),
        .ciphertext (ciphertext),
        .key_chain  (key_chain)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [7:0] sbox_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? (8'(x << 1) ^ 8'h1b) : 8'(x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_m[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic void aes_model(input logic [127:0] pt, input logic [255:0] key,
                                      output logic [127:0] ct, output logic [1919:0] kc);
        logic [31:0] w [60];
        logic [7:0]  s [4][4];
        logic [7:0]  t [4][4];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int i = 0; i < 15; i++) kc[1919-128*i -: 128] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(r+4*c) -: 8] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 14; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbox_m[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 14) begin
                    s[0][c] = gmul(8'h02, t[0][c]) ^ gmul(8'h03, t[1][c]) ^ t[2][c] ^ t[3][c];
                    s[1][c] = t[0][c] ^ gmul(8'h02, t[1][c]) ^ gmul(8'h03, t[2][c]) ^ t[3][c];
                    s[2][c] = t[0][c] ^ t[1][c] ^ gmul(8'h02, t[2][c]) ^ gmul(8'h03, t[3][c]);
                    s[3][c] = gmul(8'h03, t[0][c]) ^ t[1][c] ^ t[2][c] ^ gmul(8'h02, t[3][c]);
                end else begin
                    for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
                end
                for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                ct[127-8*(r+4*c) -: 8] = s[r][c];
    endfunction

    // Edges since reset released; the model is evaluated on the load edge.
    int unsigned   k = 0;
    logic          seen_rst = 1'b0;
    logic [127:0]  m_ct = '0;
    logic [1919:0] m_kc = '0;

    always @(posedge clk) begin
        if (reset_i === 1'b1) begin
            k        = 0;
            seen_rst = 1'b1;
        end else if (seen_rst) begin
            if (k == 0) aes_model(plaintext, initial_key, m_ct, m_kc);
            if (k < 1000) k++;
        end
    end

    // Per-cycle compare: ciphertext appears at edge 15; slot i fills at edge max(1, i+1).
    always @(negedge clk) begin
        if (seen_rst) begin
            check("ct_cycle", ciphertext, (k >= 15) ? m_ct : 128'h0);
            for (int i = 0; i < 15; i++) begin
                automatic int unsigned fill_at = (i < 2) ? 1 : i + 1;
                check($sformatf("kc_slot%0d_cycle", i), key_chain[1919-128*i -: 128],
                      (k >= fill_at) ? m_kc[1919-128*i -: 128] : 128'h0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [127:0]  p_ct;
    logic [1919:0] p_kc;

    initial begin
        reset_i     = 1'b1;
        plaintext   = '0;
        initial_key = '0;

        build_sbox();
        check("model_sbox_00", 128'(sbox_m[8'h00]), 128'h63);
        check("model_sbox_53", 128'(sbox_m[8'h53]), 128'hed);
        check("model_sbox_ff", 128'(sbox_m[8'hff]), 128'h16);
        aes_model(PT_C3, KEY_C3, p_ct, p_kc);
        check("model_c3_ct", p_ct, CT_C3);
        check("model_c3_rk14", p_kc[127:0], RK14_C3);
        aes_model(128'h0, 256'h0, p_ct, p_kc);
        check("model_zero_ct", p_ct, CT_ZERO);

        // Reset held high for several cycles.
        step(4);
        check("rst_ct", ciphertext, 128'h0);
        check("rst_kc_lo", key_chain[127:0], 128'h0);
        check("rst_kc_hi", key_chain[1919:1792], 128'h0);

        // C.3 run, inputs scrambled right after the load edge.
        plaintext   = PT_C3;
        initial_key = KEY_C3;
        reset_i     = 1'b0;
        step(1);
        plaintext   = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        initial_key = ~KEY_C3;
        step(13);
        check("lat14_ct", ciphertext, 128'h0);
        step(1);
        check("lat15_ct", ciphertext, CT_C3);
        check("c3_rk0", key_chain[1919:1792], KEY_C3[255:128]);
        check("c3_rk1", key_chain[1791:1664], KEY_C3[127:0]);
        check("c3_rk14", key_chain[127:0], RK14_C3);
        step(35);
        check("c3_hold_ct", ciphertext, CT_C3);
        check("c3_hold_rk14", key_chain[127:0], RK14_C3);

        // Restart with C.3, abort around round 7, then run the all-zero vector.
        reset_i = 1'b1;
        step(1);
        plaintext   = PT_C3;
        initial_key = KEY_C3;
        reset_i     = 1'b0;
        step(7);
        reset_i = 1'b1;
        step(1);
        check("abort_ct", ciphertext, 128'h0);
        check("abort_rk0", key_chain[1919:1792], 128'h0);
        check("abort_rk6", key_chain[1919-128*6 -: 128], 128'h0);
        plaintext   = '0;
        initial_key = '0;
        reset_i     = 1'b0;
        step(14);
        check("zero_lat14_ct", ciphertext, 128'h0);
        step(1);
        check("zero_ct", ciphertext, CT_ZERO);
        step(35);
        check("zero_hold_ct", ciphertext, CT_ZERO);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
